// File: rtl/alu_mul_seq_if.sv
// ---------------------------------------------------------------------------
// alu_mul_seq_if
//
// Operand/opcode/result bus between an initiator (the sequential multiplier)
// and the combinational datapath ALU.
//
// Signals
//   alu_op   [2:0]  ALU opcode: AND=000 OR=001 ADD=010 XOR=011 SUB=100
//                   SHR(logical)=101 SHL=110 NOR=111
//   alu_a    [31:0] operand A
//   alu_b    [31:0] operand B (shift amount for shift ops)
//   alu_r    [31:0] result, combinational from op/a/b in the same cycle
//   alu_zero        high when alu_r == 0
//
// Modports
//   master : the initiator, drives op/a/b and samples r/zero
//   slave  : the ALU, samples op/a/b and drives r/zero
// ---------------------------------------------------------------------------
interface alu_mul_seq_if;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_r;
    logic        alu_zero;

    modport master (
        output alu_op,
        output alu_a,
        output alu_b,
        input  alu_r,
        input  alu_zero
    );

    modport slave (
        input  alu_op,
        input  alu_a,
        input  alu_b,
        output alu_r,
        output alu_zero
    );
endinterface

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//
// Sequential 32x32 shift-and-add multiplier that borrows the datapath ALU
// instead of owning a multiplier array. It returns the low 32 bits of
// multiplicand*multiplier (MIPS `mul` semantics) behind a start/done
// handshake. Only the ALU's OR, ADD, SHL and SHR operations are used.
//
// Ports
//   clk           in   sole clock, rising edge
//   reset_n       in   synchronous active-low reset
//   start         in   request, sampled only in IDLE
//   multiplicand  in   [31:0] operand A, captured on an accepted start
//   multiplier    in   [31:0] operand B, captured on an accepted start
//   busy          out  high in CHECK, ADD, SHL and SHR
//   done          out  one-cycle pulse, product valid in this cycle
//   product       out  [31:0] low 32 bits of the product, held until the
//                      next done
//   alu           master side of the ALU bus (op/a/b out, r/zero in)
//
// Latency: with k = index of the highest set multiplier bit + 1 (0 for a
// zero multiplier) and p = popcount(multiplier), done rises L = 2 + 2k + p
// cycles after the start cycle. The ALU is only driven meaningfully while
// busy; in IDLE and DONE it sees op=000, a=0, b=0 and may be taken by
// another user.
// ---------------------------------------------------------------------------
module alu_mul_seq (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [31:0]          multiplicand,
    input  logic [31:0]          multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          product,
    alu_mul_seq_if.master        alu
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ADD   = 3'd2,
        S_SHL   = 3'd3,
        S_SHR   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [2:0] OP_IDLE = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;

    state_t      state;
    state_t      state_nx;

    logic [31:0] acc;   // running partial product
    logic [31:0] mc;    // multiplicand, shifted left one place per bit
    logic [31:0] mp;    // multiplier, shifted right one place per bit

    logic [2:0]  op_d;
    logic [31:0] a_d;
    logic [31:0] b_d;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    //
    // CHECK and SHR both decide on the ALU's view of the multiplier: CHECK
    // passes mp through OR-with-zero so alu_zero tells whether any bits are
    // left; SHR sees the shifted value directly, so its bit 0 is the next
    // multiplier bit to consume.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                if (alu.alu_zero) begin
                    state_nx = S_DONE;
                end else if (mp[0]) begin
                    state_nx = S_ADD;
                end else begin
                    state_nx = S_SHL;
                end
            end
            S_ADD: begin
                state_nx = S_SHL;
            end
            S_SHL: begin
                state_nx = S_SHR;
            end
            S_SHR: begin
                if (alu.alu_zero) begin
                    state_nx = S_DONE;
                end else if (alu.alu_r[0]) begin
                    state_nx = S_ADD;
                end else begin
                    state_nx = S_SHL;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic (Moore): ALU request and handshake flags depend only on
    // the state and the operand registers.
    // -----------------------------------------------------------------------
    always_comb begin
        op_d = OP_IDLE;
        a_d  = 32'd0;
        b_d  = 32'd0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_CHECK: begin
                op_d = OP_OR;
                a_d  = mp;
                b_d  = 32'd0;
                busy = 1'b1;
            end
            S_ADD: begin
                op_d = OP_ADD;
                a_d  = acc;
                b_d  = mc;
                busy = 1'b1;
            end
            S_SHL: begin
                op_d = OP_SHL;
                a_d  = mc;
                b_d  = 32'd1;
                busy = 1'b1;
            end
            S_SHR: begin
                op_d = OP_SHR;
                a_d  = mp;
                b_d  = 32'd1;
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                op_d = OP_IDLE;
            end
        endcase
    end

    assign alu.alu_op = op_d;
    assign alu.alu_a  = a_d;
    assign alu.alu_b  = b_d;

    // -----------------------------------------------------------------------
    // Operand / accumulator registers
    //
    // Each working register is written back from the ALU result in the state
    // that drove it. product is loaded on the edge that enters DONE; acc is
    // already final there because entry into DONE only happens from CHECK or
    // SHR, neither of which writes acc.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc     <= 32'd0;
            mc      <= 32'd0;
            mp      <= 32'd0;
            product <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc <= 32'd0;
                        mc  <= multiplicand;
                        mp  <= multiplier;
                    end
                end
                S_ADD: begin
                    acc <= alu.alu_r;
                end
                S_SHL: begin
                    mc <= alu.alu_r;
                end
                S_SHR: begin
                    mp <= alu.alu_r;
                end
                default: begin
                end
            endcase

            if (state_nx == S_DONE && state != S_DONE) begin
                product <= acc;
            end
        end
    end

endmodule
